// File: rtl/aes_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_ctrl_pkg                                                    |
// | Purpose  : State enum and message-register mux encodings shared by the     |
// |            AES encryption and decryption controllers.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        KEYEXP   = 4'd1,
        ARK_INIT = 4'd2,
        SB       = 4'd3,
        SR       = 4'd4,
        MC       = 4'd5,
        MC_WB    = 4'd6,
        ARK      = 4'd7,
        DONE     = 4'd8
    } aes_state_e;

    localparam logic [2:0] SEL_ARK  = 3'b000;
    localparam logic [2:0] SEL_SR   = 3'b001;
    localparam logic [2:0] SEL_MCWB = 3'b010;
    localparam logic [2:0] SEL_SB   = 3'b011;
    localparam logic [2:0] SEL_LOAD = 3'b100;

endpackage

`default_nettype wire

// File: rtl/aes_encrypt_control_if.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_encrypt_control_if                                          |
// | Purpose  : Request/done handshake and datapath control bundle of the AES   |
// |            encryption controller. AES_ABORT exists only with AES_ABORT_EN. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface aes_encrypt_control_if;

    logic       AES_START;
`ifdef AES_ABORT_EN
    logic       AES_ABORT;
`endif
    logic       AES_DONE;
    logic [2:0] regSelect;
    logic [1:0] mcSelect;
    logic [3:0] arkSelect;
    logic       msgRegLE;
    logic       barrierRegLE;

    modport slave (
`ifdef AES_ABORT_EN
        input  AES_ABORT,
`endif
        input  AES_START,
        output AES_DONE,
        output regSelect,
        output mcSelect,
        output arkSelect,
        output msgRegLE,
        output barrierRegLE
    );

    modport master (
`ifdef AES_ABORT_EN
        output AES_ABORT,
`endif
        output AES_START,
        input  AES_DONE,
        input  regSelect,
        input  mcSelect,
        input  arkSelect,
        input  msgRegLE,
        input  barrierRegLE
    );

endinterface

`default_nettype wire

// File: rtl/aes_encrypt_control.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_encrypt_control                                             |
// | Purpose  : Forward AES cipher control FSM with round/step counters.        |
// |            Define AES_ABORT_EN to add the AES_ABORT early-exit input.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_encrypt_control
    import aes_ctrl_pkg::*;
#(
    parameter int KE_CYCLES  = 11,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    aes_encrypt_control_if.slave  bus
);

    localparam logic [3:0] c_ke_last    = 4'(KE_CYCLES - 1);
    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

    aes_state_e state_q;
    logic [3:0] round_q;
    logic [3:0] step_q;
    logic       w_abort;

`ifdef AES_ABORT_EN
    assign w_abort = bus.AES_ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // step is reused in DONE to enforce the two-cycle minimum dwell
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            round_q <= '0;
            step_q  <= '0;
        end else if (w_abort && (state_q != IDLE)) begin
            state_q <= IDLE;
            round_q <= '0;
            step_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.AES_START) begin
                        state_q <= KEYEXP;
                        step_q  <= '0;
                    end
                end
                KEYEXP: begin
                    step_q <= step_q + 4'd1;
                    if (step_q == c_ke_last) begin
                        state_q <= ARK_INIT;
                        step_q  <= '0;
                    end
                end
                ARK_INIT: begin
                    round_q <= 4'd1;
                    state_q <= SB;
                end
                SB: state_q <= SR;
                SR: begin
                    if (round_q == c_last_round) begin
                        state_q <= ARK;
                    end else begin
                        state_q <= MC;
                        step_q  <= '0;
                    end
                end
                MC: begin
                    step_q <= step_q + 4'd1;
                    if (step_q == 4'd3) begin
                        state_q <= MC_WB;
                    end
                end
                MC_WB: state_q <= ARK;
                ARK: begin
                    if (round_q == c_last_round) begin
                        state_q <= DONE;
                        step_q  <= '0;
                    end else begin
                        round_q <= round_q + 4'd1;
                        state_q <= SB;
                    end
                end
                DONE: begin
                    if (step_q == 4'd0) begin
                        step_q <= 4'd1;
                    end else if (!bus.AES_START) begin
                        state_q <= IDLE;
                        round_q <= '0;
                        step_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    round_q <= '0;
                    step_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.AES_DONE     = 1'b0;
        bus.regSelect    = SEL_ARK;
        bus.mcSelect     = 2'd0;
        bus.arkSelect    = 4'd0;
        bus.msgRegLE     = 1'b0;
        bus.barrierRegLE = 1'b0;
        case (state_q)
            IDLE: begin
                bus.regSelect = SEL_LOAD;
                bus.msgRegLE  = 1'b1;
            end
            ARK_INIT: begin
                bus.regSelect = SEL_ARK;
                bus.msgRegLE  = 1'b1;
            end
            SB: begin
                bus.regSelect = SEL_SB;
                bus.msgRegLE  = 1'b1;
            end
            SR: begin
                bus.regSelect = SEL_SR;
                bus.msgRegLE  = 1'b1;
            end
            MC: begin
                bus.mcSelect     = step_q[1:0];
                bus.barrierRegLE = 1'b1;
            end
            MC_WB: begin
                bus.regSelect = SEL_MCWB;
                bus.msgRegLE  = 1'b1;
            end
            ARK: begin
                bus.arkSelect = round_q;
                bus.regSelect = SEL_ARK;
                bus.msgRegLE  = 1'b1;
            end
            DONE: bus.AES_DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_control.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_encrypt_control                                          |
// | Purpose  : Scoreboard bench for aes_encrypt_control against a run-plan     |
// |            reference model; honours AES_ABORT_EN when defined.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_encrypt_control;

    localparam int KE = 11;
    localparam int NR = 10;
`ifdef AES_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    typedef struct packed {
        logic       done;
        logic [2:0] sel;
        logic [1:0] mc;
        logic [3:0] ark;
        logic       msg;
        logic       bar;
    } out_t;

    logic clk;
    logic rst_n;
    aes_encrypt_control_if bus ();

    aes_encrypt_control #(.KE_CYCLES(KE), .NUM_ROUNDS(NR)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t exp_q[$];
    out_t plan[$];
    int   mode;        // 0 idle, 1 running the plan, 2 done
    int   dcnt;
    bit   sb_on;
    int   vectors;
    int   miscompares;

    function automatic out_t mk(input bit d, input int s, input int m, input int a,
                                input bit ml, input bit bl);
        out_t o;
        o.done = d; o.sel = 3'(s); o.mc = 2'(m); o.ark = 4'(a); o.msg = ml; o.bar = bl;
        return o;
    endfunction

    // Whole encryption expressed as the list of per-cycle output tuples
    task automatic build_plan();
        plan.delete();
        for (int i = 0; i < KE; i++) plan.push_back(mk(0, 0, 0, 0, 0, 0));
        plan.push_back(mk(0, 0, 0, 0, 1, 0));
        for (int r = 1; r < NR; r++) begin
            plan.push_back(mk(0, 3, 0, 0, 1, 0));
            plan.push_back(mk(0, 1, 0, 0, 1, 0));
            for (int c = 0; c < 4; c++) plan.push_back(mk(0, 0, c, 0, 0, 1));
            plan.push_back(mk(0, 2, 0, 0, 1, 0));
            plan.push_back(mk(0, 0, 0, r, 1, 0));
        end
        plan.push_back(mk(0, 3, 0, 0, 1, 0));
        plan.push_back(mk(0, 1, 0, 0, 1, 0));
        plan.push_back(mk(0, 0, 0, NR, 1, 0));
    endtask

    function automatic out_t model_out();
        if (mode == 1) return plan[0];
        if (mode == 2) return mk(1, 0, 0, 0, 0, 0);
        return mk(0, 4, 0, 0, 1, 0);
    endfunction

    task automatic model_step(input bit start, input bit rstn, input bit abort);
        if (!rstn || (ABORT_ON && abort && mode != 0)) begin
            mode = 0;
            plan.delete();
        end else if (mode == 0) begin
            if (start) begin
                build_plan();
                mode = 1;
            end
        end else if (mode == 1) begin
            void'(plan.pop_front());
            if (plan.size() == 0) begin
                mode = 2;
                dcnt = 1;
            end
        end else begin
            if (dcnt >= 2 && !start) mode = 0;
            else dcnt++;
        end
    endtask

    // Called just after a rising edge: records this period's expectation, drives the next edge
    task automatic cycle(input bit start, input bit rstn, input bit abort);
        if (sb_on) exp_q.push_back(model_out());
        bus.AES_START = start;
        rst_n = rstn;
`ifdef AES_ABORT_EN
        bus.AES_ABORT = abort;
`endif
        model_step(start, rstn, abort);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int start_len, input int rst_at, input int abort_at, input int total);
        for (int c = 0; c < total; c++) cycle(c < start_len, c != rst_at, c == abort_at);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    out_t act;
    out_t expv;
    int   n_cyc, n_msg, n_bar;
    bit   prev_done;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            expv = exp_q.pop_front();
            act  = {bus.AES_DONE, bus.regSelect, bus.mcSelect, bus.arkSelect,
                    bus.msgRegLE, bus.barrierRegLE};
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL outputs t=%0t act done=%b sel=%b mc=%0d ark=%0d msg=%b bar=%b exp done=%b sel=%b mc=%0d ark=%0d msg=%b bar=%b",
                         $time, act.done, act.sel, act.mc, act.ark, act.msg, act.bar,
                         expv.done, expv.sel, expv.mc, expv.ark, expv.msg, expv.bar);
            end
            if (act.sel == 3'b100 && act.msg && !act.done) begin
                n_cyc = 0; n_msg = 0; n_bar = 0;
            end else begin
                n_cyc++;
                n_msg += int'(act.msg);
                n_bar += int'(act.bar);
                if (act.done && !prev_done) begin
                    vectors++;
                    if (n_cyc != KE + 1 + 8 * (NR - 1) + 3 + 1 ||
                        n_msg != 1 + 4 * (NR - 1) + 3 || n_bar != 4 * (NR - 1)) begin
                        miscompares++;
                        $display("FAIL run_stats act lat=%0d msg=%0d bar=%0d exp lat=%0d msg=%0d bar=%0d",
                                 n_cyc, n_msg, n_bar, KE + 1 + 8 * (NR - 1) + 4,
                                 1 + 4 * (NR - 1) + 3, 4 * (NR - 1));
                    end
                end
            end
            prev_done = act.done;
        end
    end

    initial begin
        int sl, ra, aa, tot;
        mode = 0; dcnt = 0; sb_on = 1'b0;
        vectors = 0; miscompares = 0;
        n_cyc = 0; n_msg = 0; n_bar = 0; prev_done = 1'b0;
        rst_n = 1'b0;
        bus.AES_START = 1'b0;
`ifdef AES_ABORT_EN
        bus.AES_ABORT = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        sb_on = 1'b1;

        idle(3);
        run(1, -1, -1, 95);
        idle(2);
        run(120, -1, -1, 126);
        run(1, -1, -1, 95);
        run(3, 49, -1, 52);
        run(1, -1, -1, 95);
        run(1, -1, 40, 95);
        idle(2);

        repeat (8) begin
            sl  = int'($urandom_range(1, 110));
            ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 85)) : -1;
            aa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 85)) : -1;
            tot = 95 + ((sl > 88) ? sl - 88 : 0) + int'($urandom_range(0, 5));
            run(sl, ra, aa, tot);
            idle(int'($urandom_range(0, 4)));
        end
        idle(120);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
